// File: rtl/pc_unit.sv
// Program counter with increment, add-offset and subtract-offset requests.
// Requests are prioritised inc > add > sub; with no request pc holds.
// All arithmetic wraps modulo 2^WIDTH. Carry, borrow and overflow are dropped.
module pc_unit #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] INC_STEP    = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             add,
  input  logic             sub,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_next;

  // Pick the next pc from the highest-priority request. offset is only read
  // on the add/sub paths, so an unknown offset cannot reach pc while idle.
  always_comb begin
    pc_next = pc;
    if (inc) begin
      pc_next = pc + INC_STEP;
    end else if (add) begin
      pc_next = pc + offset;
    end else if (sub) begin
      pc_next = pc - offset;
    end
  end

  // pc register. Reset is asynchronous and active-low. pc is driven straight
  // from this flop, so the request inputs have no combinational path to pc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_VALUE;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit. Expected pc values come from a bench-side
// model, are queued when a request is driven, and are popped after the edge.
module tb_pc_unit;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             inc;
  logic             add;
  logic             sub;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] pc;

  logic [WIDTH-1:0] model_pc;
  logic [WIDTH-1:0] exp_q[$];
  int               n_checks;
  int               n_fail;

  pc_unit #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(16'h0000),
    .INC_STEP   (16'h0001)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .add   (add),
    .sub   (sub),
    .offset(offset),
    .pc    (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expected value and compare it against pc.
  task automatic pop_check(input string name);
    logic [WIDTH-1:0] exp_v;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, pc=%h", name, pc);
    end else begin
      exp_v = exp_q.pop_front();
      if (pc !== exp_v) begin
        n_fail++;
        $display("FAIL %s: pc=%h expected=%h", name, pc, exp_v);
      end
    end
  endtask

  // Drive one request at the falling edge, update the model, push the
  // expected value, then check one time unit after the capturing edge.
  task automatic step(input logic i, input logic a, input logic s,
                      input logic [WIDTH-1:0] off, input string name);
    @(negedge clk);
    inc    = i;
    add    = a;
    sub    = s;
    offset = off;
    if (i)      model_pc = model_pc + 16'h0001;
    else if (a) model_pc = model_pc + off;
    else if (s) model_pc = model_pc - off;
    exp_q.push_back(model_pc);
    @(posedge clk);
    #1;
    pop_check(name);
  endtask

  task automatic direct_check(input logic [WIDTH-1:0] exp_v, input string name);
    n_checks++;
    if (pc !== exp_v) begin
      n_fail++;
      $display("FAIL %s: pc=%h expected=%h", name, pc, exp_v);
    end
  endtask

  task automatic test_reset();
    // Reset is already low from time 0; requests are active during reset.
    #2;
    direct_check(16'h0000, "reset_t0");
    inc = 1'b1; add = 1'b1; sub = 1'b1; offset = 16'h5555;
    @(posedge clk); #1;
    direct_check(16'h0000, "reset_hold_edge1");
    @(posedge clk); #1;
    direct_check(16'h0000, "reset_hold_edge2");
    @(negedge clk);
    inc = 1'b0; add = 1'b0; sub = 1'b0;
    reset = 1'b1;
    model_pc = 16'h0000;
    #1;
    direct_check(16'h0000, "reset_release");
    step(1'b0, 1'b0, 1'b0, 16'h1111, "idle_after_reset_1");
    step(1'b0, 1'b0, 1'b0, 16'h2222, "idle_after_reset_2");
  endtask

  task automatic test_sequence();
    step(1'b1, 1'b0, 1'b0, 16'h0000, "seq_inc");
    step(1'b0, 1'b1, 1'b0, 16'h00A5, "seq_add_a5");
    step(1'b0, 1'b0, 1'b0, 16'hxxxx, "seq_idle_offset_x");
    step(1'b1, 1'b0, 1'b0, 16'h0000, "seq_inc2");
    step(1'b0, 1'b0, 1'b1, 16'h0014, "seq_sub_14");
  endtask

  task automatic test_wrap();
    // Bring pc to 0000 with a subtract of itself.
    step(1'b0, 1'b0, 1'b1, model_pc, "wrap_to_zero");
    step(1'b0, 1'b0, 1'b1, 16'h0001, "wrap_sub_borrow");
    step(1'b1, 1'b0, 1'b0, 16'h0000, "wrap_inc_carry");
    step(1'b0, 1'b1, 1'b0, 16'hFFF0, "wrap_load_fff0");
    step(1'b0, 1'b1, 1'b0, 16'h0020, "wrap_add_carry");
  endtask

  task automatic test_priority();
    // pc is 0010 here.
    step(1'b1, 1'b1, 1'b1, 16'h0005, "prio_inc_add_sub");
    step(1'b0, 1'b0, 1'b1, 16'h0001, "prio_back_to_10");
    step(1'b0, 1'b1, 1'b1, 16'h0005, "prio_add_sub");
    step(1'b0, 1'b0, 1'b1, 16'h0005, "prio_back_to_10b");
    step(1'b0, 1'b0, 1'b1, 16'h0005, "prio_sub_only");
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 1'b0, 16'h1234 - model_pc, "async_load_1234");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    direct_check(16'h0000, "async_reset_immediate");
    inc = 1'b1; add = 1'b1; sub = 1'b0; offset = 16'h0F0F;
    @(posedge clk); #1;
    direct_check(16'h0000, "async_reset_req_ignored");
    @(negedge clk);
    inc = 1'b0; add = 1'b0; sub = 1'b0;
    reset = 1'b1;
    model_pc = 16'h0000;
    step(1'b0, 1'b0, 1'b0, 16'h0000, "async_after_release_idle");
    step(1'b1, 1'b0, 1'b0, 16'h0000, "async_after_release_inc");
  endtask

  task automatic test_glitch();
    @(negedge clk);
    inc = 1'b0; add = 1'b0; sub = 1'b0; offset = 16'h0003;
    #1 inc = 1'b1;
    #1 inc = 1'b0;
    exp_q.push_back(model_pc);
    @(posedge clk);
    #1;
    pop_check("glitch_inc_pulse");
  endtask

  task automatic test_back_to_back();
    logic             i, a, s;
    logic [WIDTH-1:0] off;
    for (int k = 0; k < 24; k++) begin
      i   = 1'($urandom_range(0, 1));
      a   = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      off = 16'($urandom);
      step(i, a, s, off, "back_to_back");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_pc = 16'h0000;
    reset    = 1'b0;
    inc      = 1'b0;
    add      = 1'b0;
    sub      = 1'b0;
    offset   = '0;
    test_reset();
    test_sequence();
    test_wrap();
    test_priority();
    test_async_reset();
    test_glitch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Parameters
- REQ-001: WIDTH, default 16, SHALL set the width of the program counter and of the offset.
- REQ-002: RESET_VALUE, default 16'h0000, SHALL be the value loaded into pc on reset.
- REQ-003: INC_STEP, default 1, SHALL be the amount added to pc by an increment.

Interface
- REQ-004: One clock; reset is asynchronous and active-low.
- REQ-005: clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
- REQ-006: reset  input  1  SHALL be the asynchronous, active-low reset.
- REQ-007: inc  input  1  SHALL request pc <= pc + INC_STEP.
- REQ-008: add  input  1  SHALL request pc <= pc + offset.
- REQ-009: sub  input  1  SHALL request pc <= pc - offset.
- REQ-010: offset  input  WIDTH  SHALL be the unsigned branch displacement used by add and sub.
- REQ-011: pc  output  WIDTH  SHALL be the current program counter, driven directly from a register.

Function
- REQ-012: On each rising clk edge with reset high, pc SHALL update per the highest-priority asserted request, in the order inc > add > sub.
- REQ-013: With inc=1, pc SHALL become pc + INC_STEP; add, sub and offset SHALL be ignored.
- REQ-014: With inc=0 and add=1, pc SHALL become pc + offset; sub SHALL be ignored.
- REQ-015: With inc=0, add=0 and sub=1, pc SHALL become pc - offset.
- REQ-016: With inc, add and sub all 0, pc SHALL hold its value; offset SHALL be don't-care, and X on offset SHALL NOT corrupt pc.
- REQ-017: All arithmetic SHALL be modulo 2^WIDTH.
  - Carry out of the addition is discarded: FFFF + 1 = 0000.
  - Borrow out of the subtraction is discarded: 0000 - 1 = FFFF.
  - No overflow flag is produced.
- REQ-018: Latency SHALL be one cycle: the new pc is visible immediately after the capturing edge.
- REQ-019: pc SHALL have no combinational path from inc, add, sub or offset.
- REQ-020: Control inputs SHALL be sampled only at rising clk edges; changes between edges SHALL NOT affect pc.

Reset
- REQ-021: When reset goes low, pc SHALL become RESET_VALUE immediately, without waiting for a clock edge.
- REQ-022: While reset is low, pc SHALL hold RESET_VALUE regardless of clk, inc, add, sub and offset.
- REQ-023: Reset asserted mid-operation SHALL abort any pending update; no partial value SHALL appear on pc.
- REQ-024: After reset deasserts, the first rising clk edge with reset high SHALL apply normal operation.
- REQ-025: Reset deassertion SHALL be treated as synchronous to clk by the integrator; no internal synchronizer is required.

Verification
- REQ-026: Reset low at time 0, released mid-cycle -> pc = 0000 throughout reset, then holds 0000 until the first request.
- REQ-027: From 0000, apply the following, one per edge -> pc reads 0001, 00A6, 00A6, 00A7, 0093:
  - inc
  - add with offset=00A5
  - idle with offset=X
  - inc
  - sub with offset=0014
- REQ-028: Wrap-around -> with pc=FFFF, inc gives 0000; with pc=0000, sub with offset=0001 gives FFFF; with pc=FFF0, add with offset=0020 gives 0010.
- REQ-029: Priority, with pc=0010 and offset=0005 -> inc+add+sub gives 0011; add+sub gives 0015; sub alone gives 000B.
- REQ-030: Asynchronous reset -> with pc=1234, pull reset low between clock edges -> pc = 0000 before the next edge; requests asserted during reset have no effect.
- REQ-031: Mid-cycle glitch -> toggle inc high then low between edges -> pc unchanged at the next edge.
